// File: rtl/matrix_frame_scheduler_pkg.sv
// Shared types, defaults and helpers for the LED-matrix frame scheduler.
package matrix_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SER_SETUP,
    SCLK_HIGH,
    SCLK_LOW,
    LATCH,
    SPI_KICK,
    SPI_WAIT,
    NEXT,
    DONE
  } state_t;

  localparam int CHANNEL_NUMBER_DEF     = 3;
  localparam int BYTES_PER_MATRIX_DEF   = 8;
  localparam int MATRIX_PER_CHANNEL_DEF = 4;
  localparam int DIV_FACTOR_DEF         = 2;
  localparam int TIMEOUT_CYCLES_DEF     = 65535;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_frame_scheduler_if.sv
// Frame-buffer / SPI / HC595 signal bundle seen by the frame scheduler.
// master: the scheduler itself; slave: the surrounding LED_Matrix_top logic.
interface matrix_frame_scheduler_if
  import matrix_pkg::*;
#(
  parameter int CHANNEL_NUMBER     = CHANNEL_NUMBER_DEF,
  parameter int MATRIX_PER_CHANNEL = MATRIX_PER_CHANNEL_DEF
);
  localparam int IDX_W = idx_width(MATRIX_PER_CHANNEL);

  logic                      frame_start;
  logic [CHANNEL_NUMBER-1:0] spi_done;
  logic                      spi_start;
  logic [IDX_W-1:0]          matrix_index;
  logic                      shift_clk;
  logic                      shift_ser;
  logic                      shift_stcp;
  logic                      shift_en;
  logic                      busy;
  logic                      frame_done;
  logic                      timeout_err;
  logic                      overrun;

  modport master (
    input  frame_start, spi_done,
    output spi_start, matrix_index, shift_clk, shift_ser, shift_stcp,
           shift_en, busy, frame_done, timeout_err, overrun
  );

  modport slave (
    output frame_start, spi_done,
    input  spi_start, matrix_index, shift_clk, shift_ser, shift_stcp,
           shift_en, busy, frame_done, timeout_err, overrun
  );

endinterface

// File: rtl/matrix_frame_scheduler_phase_gen.sv
// HC595 phase timer: each shift phase lasts DIV_FACTOR clk cycles.
// phase_done strobes on the last cycle of a phase while run is high.
module hc595_phase_gen
  import matrix_pkg::*;
#(
  parameter int DIV_FACTOR = DIV_FACTOR_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic phase_done
);
  localparam int              PC_W    = idx_width(DIV_FACTOR);
  localparam logic [PC_W-1:0] PC_LOAD = PC_W'(DIV_FACTOR - 1);

  logic [PC_W-1:0] pc;

  assign phase_done = run && (pc == '0);

  // Down-counter, reloaded while idle and at every terminal count.
  always_ff @(posedge clk) begin
    if (rst || !run || pc == '0) begin
      pc <= PC_LOAD;
    end else begin
      pc <= pc - PC_W'(1);
    end
  end

endmodule

// File: rtl/matrix_frame_scheduler.sv
// Sequences one LED-matrix frame: per slot, shift a one-hot select into the
// HC595 chain, latch it, kick all SPI channels, wait for every channel's done.
// After the last slot one extra 0 is shifted and latched to deselect all.
//
// state     | meaning
// IDLE      | waiting for frame_start or a pending request
// SER_SETUP | drive SER for this shift, SRCLK low
// SCLK_HIGH | SRCLK high (shift)
// SCLK_LOW  | SRCLK low
// LATCH     | RCLK high, outputs enabled
// SPI_KICK  | one-cycle spi_start, clear done mask and watchdog
// SPI_WAIT  | collect spi_done bits, watchdog running
// NEXT      | advance slot or start the deselect pass
// DONE      | frame_done pulse, back to IDLE
module matrix_frame_scheduler
  import matrix_pkg::*;
#(
  parameter int CHANNEL_NUMBER     = CHANNEL_NUMBER_DEF,
  parameter int MATRIX_PER_CHANNEL = MATRIX_PER_CHANNEL_DEF,
  parameter int DIV_FACTOR         = DIV_FACTOR_DEF,
  parameter int TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF
) (
  input logic                       clk,
  input logic                       rst,
  matrix_frame_scheduler_if.master  bus
);
  localparam int               IDX_W    = idx_width(MATRIX_PER_CHANNEL);
  localparam int               WD_W     = idx_width(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_PER_CHANNEL - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  state_t                    state;
  logic                      pending;
  logic                      clearing;
  logic [CHANNEL_NUMBER-1:0] done_mask;
  logic [CHANNEL_NUMBER-1:0] mask_next;
  logic [WD_W-1:0]           wd;
  logic                      phase_run;
  logic                      phase_done;

  logic             spi_start_q;
  logic [IDX_W-1:0] idx_q;
  logic             shift_clk_q;
  logic             shift_ser_q;
  logic             shift_stcp_q;
  logic             shift_en_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             timeout_err_q;
  logic             overrun_q;

  assign phase_run = (state == SER_SETUP) || (state == SCLK_HIGH) ||
                     (state == SCLK_LOW)  || (state == LATCH);
  assign mask_next = done_mask | bus.spi_done;

  hc595_phase_gen #(.DIV_FACTOR(DIV_FACTOR)) u_phase (
    .clk        (clk),
    .rst        (rst),
    .run        (phase_run),
    .phase_done (phase_done)
  );

  // Main sequencer; every pin level is registered on the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pending       <= 1'b0;
      clearing      <= 1'b0;
      done_mask     <= '0;
      wd            <= '0;
      spi_start_q   <= 1'b0;
      idx_q         <= '0;
      shift_clk_q   <= 1'b0;
      shift_ser_q   <= 1'b0;
      shift_stcp_q  <= 1'b0;
      shift_en_q    <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      spi_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;

      // One request can queue behind the running frame; a second is dropped.
      if (state != IDLE && bus.frame_start) begin
        if (pending) overrun_q <= 1'b1;
        else         pending   <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (bus.frame_start || pending) begin
            state       <= SER_SETUP;
            busy_q      <= 1'b1;
            idx_q       <= '0;
            // A fresh request arriving while a pending one is consumed stays queued.
            pending     <= pending && bus.frame_start;
            shift_ser_q <= 1'b1;
            shift_clk_q <= 1'b0;
          end
        end
        SER_SETUP: begin
          if (phase_done) begin
            state       <= SCLK_HIGH;
            shift_clk_q <= 1'b1;
          end
        end
        SCLK_HIGH: begin
          if (phase_done) begin
            state       <= SCLK_LOW;
            shift_clk_q <= 1'b0;
          end
        end
        SCLK_LOW: begin
          if (phase_done) begin
            state        <= LATCH;
            shift_stcp_q <= 1'b1;
            shift_en_q   <= 1'b0;
          end
        end
        LATCH: begin
          if (phase_done) begin
            shift_stcp_q <= 1'b0;
            if (clearing) begin
              state        <= DONE;
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
              clearing     <= 1'b0;
            end else begin
              state       <= SPI_KICK;
              spi_start_q <= 1'b1;
            end
          end
        end
        SPI_KICK: begin
          state     <= SPI_WAIT;
          done_mask <= '0;
          wd        <= '0;
        end
        SPI_WAIT: begin
          done_mask <= mask_next;
          if (&mask_next) begin
            state <= NEXT;
          end else if (wd == WD_LAST) begin
            state         <= NEXT;
            timeout_err_q <= 1'b1;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        NEXT: begin
          state       <= SER_SETUP;
          shift_clk_q <= 1'b0;
          // Slot 0 is only ever selected from IDLE, so every shift from here is a 0.
          shift_ser_q <= 1'b0;
          if (idx_q == LAST_IDX) clearing <= 1'b1;
          else                   idx_q    <= idx_q + IDX_W'(1);
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.spi_start    = spi_start_q;
  assign bus.matrix_index = idx_q;
  assign bus.shift_clk    = shift_clk_q;
  assign bus.shift_ser    = shift_ser_q;
  assign bus.shift_stcp   = shift_stcp_q;
  assign bus.shift_en     = shift_en_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.overrun      = overrun_q;

endmodule
